// File: rtl/nco_sine_lut_if.sv
// Phase-in / sample-out bundle between the phase accumulator, the sine LUT
// stage and the DAC/mixer datapath.
`timescale 1ns/1ps
interface nco_sine_lut_if #(
  parameter int PHASE_W = 8,
  parameter int DATA_W  = 12
);
  logic [PHASE_W-1:0] phase;
  logic               phase_valid;
  logic [DATA_W-1:0]  sin_out;
  logic [DATA_W-1:0]  cos_out;
  logic               out_valid;

  modport master (
    output phase,
    output phase_valid,
    input  sin_out,
    input  cos_out,
    input  out_valid
  );

  modport slave (
    input  phase,
    input  phase_valid,
    output sin_out,
    output cos_out,
    output out_valid
  );
endinterface

// File: rtl/nco_sine_lut.sv
// Phase-to-amplitude converter: quarter-wave sine ROM with quadrant mirroring,
// producing signed sine and cosine through a 3-stage enabled pipeline.
`timescale 1ns/1ps
module nco_sine_lut #(
  parameter int PHASE_W = 8,
  parameter int LUT_AW  = 6,
  parameter int DATA_W  = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          EN,
  nco_sine_lut_if.slave bus
);

  localparam int  LUT_N   = 2 ** LUT_AW;
  localparam real HALF_PI = 1.5707963267948966;

  // Elaboration-time sine; the series is accurate far beyond one LSB on [0, pi/2].
  function automatic real sin_series(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int table_entry(input int idx);
    real amp;
    real x;
    amp = real'((2 ** (DATA_W - 1)) - 1);
    x   = HALF_PI * (real'(idx) + 0.5) / real'(LUT_N);
    return $rtoi(amp * sin_series(x) + 0.5);
  endfunction

  // NOTE: the table is a constant ROM, so it has no reset; only pipeline state is cleared.
  logic [DATA_W-1:0] w_table [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_rom
    localparam int ENTRY = table_entry(gi);
    assign w_table[gi] = ENTRY[DATA_W-1:0];
  end

  logic [1:0]        w_q;
  logic [1:0]        w_qc;
  logic [LUT_AW-1:0] w_k;
  logic [LUT_AW-1:0] w_sin_idx;
  logic [LUT_AW-1:0] w_cos_idx;
  logic              w_sin_neg;
  logic              w_cos_neg;

  // Odd quadrants read the table mirrored, the upper half of the turn is negated.
  // NOTE: every output of a combinational block gets a default first, so no latch can be inferred.
  always_comb begin
    w_q       = bus.phase[PHASE_W-1 -: 2];
    w_k       = bus.phase[PHASE_W-3 -: LUT_AW];
    w_qc      = w_q + 2'd1;
    w_sin_idx = w_k;
    w_cos_idx = w_k;
    w_sin_neg = w_q[1];
    w_cos_neg = w_qc[1];
    if (w_q[0])  w_sin_idx = ~w_k;
    if (w_qc[0]) w_cos_idx = ~w_k;
  end

  logic [LUT_AW-1:0] r1_sin_idx;
  logic [LUT_AW-1:0] r1_cos_idx;
  logic              r1_sin_neg;
  logic              r1_cos_neg;
  logic              r1_valid;

  logic [DATA_W-1:0] r2_sin_mag;
  logic [DATA_W-1:0] r2_cos_mag;
  logic              r2_sin_neg;
  logic              r2_cos_neg;
  logic              r2_valid;

  logic [DATA_W-1:0] r3_sin;
  logic [DATA_W-1:0] r3_cos;
  logic              r3_valid;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_sin_idx <= '0;
      r1_cos_idx <= '0;
      r1_sin_neg <= 1'b0;
      r1_cos_neg <= 1'b0;
      r1_valid   <= 1'b0;
    end else if (EN) begin
      r1_sin_idx <= w_sin_idx;
      r1_cos_idx <= w_cos_idx;
      r1_sin_neg <= w_sin_neg;
      r1_cos_neg <= w_cos_neg;
      r1_valid   <= bus.phase_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_sin_mag <= '0;
      r2_cos_mag <= '0;
      r2_sin_neg <= 1'b0;
      r2_cos_neg <= 1'b0;
      r2_valid   <= 1'b0;
    end else if (EN) begin
      r2_sin_mag <= w_table[r1_sin_idx];
      r2_cos_mag <= w_table[r1_cos_idx];
      r2_sin_neg <= r1_sin_neg;
      r2_cos_neg <= r1_cos_neg;
      r2_valid   <= r1_valid;
    end
  end

  // Output data only loads on valid samples so bubbles leave the last sample in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3_sin   <= '0;
      r3_cos   <= '0;
      r3_valid <= 1'b0;
    end else if (EN) begin
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_sin <= r2_sin_neg ? -r2_sin_mag : r2_sin_mag;
        r3_cos <= r2_cos_neg ? -r2_cos_mag : r2_cos_mag;
      end
    end
  end

  assign bus.sin_out   = r3_sin;
  assign bus.cos_out   = r3_cos;
  assign bus.out_valid = r3_valid;

endmodule

// File: tb/tb_nco_sine_lut.sv
// Directed bench for nco_sine_lut: reset, quadrant points, full sweep with
// symmetry checks, EN stall, bubbles and phase wrap against a math reference.
`timescale 1ns/1ps
module tb_nco_sine_lut;

  localparam int  AMP    = 2047;
  localparam real TWO_PI = 6.283185307179586;

  logic clk = 1'b0;
  logic rst;
  logic EN;

  int checks = 0;
  int errors = 0;

  nco_sine_lut_if #(.PHASE_W(8), .DATA_W(12)) bus ();

  nco_sine_lut #(.PHASE_W(8), .LUT_AW(6), .DATA_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .EN  (EN),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected-output delay line: entry 3 is what the output stage should hold.
  logic       m_v [1:3];
  logic [7:0] m_p [1:3];
  int         held_sin;
  int         held_cos;
  int         obs_sin [256];
  int         obs_cos [256];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_round(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int ref_sin(input logic [7:0] p);
    return ref_round(real'(AMP) * $sin(TWO_PI * (real'(p) + 0.5) / 256.0));
  endfunction

  function automatic int ref_cos(input logic [7:0] p);
    return ref_round(real'(AMP) * $cos(TWO_PI * (real'(p) + 0.5) / 256.0));
  endfunction

  task automatic model_clear();
    for (int i = 1; i <= 3; i++) begin
      m_v[i] = 1'b0;
      m_p[i] = 8'h00;
    end
    held_sin = 0;
    held_cos = 0;
  endtask

  // Drive one cycle of inputs, advance the model on enabled edges, check outputs.
  task automatic step(input logic en, input logic v, input logic [7:0] p);
    EN              = en;
    bus.phase_valid = v;
    bus.phase       = p;
    @(posedge clk);
    #1;
    if (rst) begin
      model_clear();
    end else if (en) begin
      m_v[3] = m_v[2];  m_p[3] = m_p[2];
      m_v[2] = m_v[1];  m_p[2] = m_p[1];
      m_v[1] = v;       m_p[1] = p;
      if (m_v[3]) begin
        held_sin = ref_sin(m_p[3]);
        held_cos = ref_cos(m_p[3]);
      end
    end
    check("out_valid", bus.out_valid, m_v[3]);
    check("sin_out", $signed(bus.sin_out), held_sin);
    check("cos_out", $signed(bus.cos_out), held_cos);
    if (m_v[3] && !rst) begin
      obs_sin[m_p[3]] = $signed(bus.sin_out);
      obs_cos[m_p[3]] = $signed(bus.cos_out);
    end
  endtask

  initial begin
    int         prev_sin;
    bit         have_prev;
    logic [7:0] acc;

    rst             = 1'b1;
    EN              = 1'b0;
    bus.phase       = 8'h00;
    bus.phase_valid = 1'b0;
    model_clear();
    for (int i = 0; i < 256; i++) begin
      obs_sin[i] = 0;
      obs_cos[i] = 0;
    end

    #12;
    check("rst_sin", $signed(bus.sin_out), 0);
    check("rst_cos", $signed(bus.cos_out), 0);
    check("rst_valid", bus.out_valid, 1'b0);
    rst = 1'b0;

    // Quadrant points, back to back.
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h40);
    step(1'b1, 1'b1, 8'h80);
    check("q0_sin", $signed(bus.sin_out), 25);
    check("q0_cos", $signed(bus.cos_out), 2047);
    step(1'b1, 1'b1, 8'hC0);
    check("q1_sin", $signed(bus.sin_out), 2047);
    check("q1_cos", $signed(bus.cos_out), -25);
    step(1'b1, 1'b0, 8'h00);
    check("q2_sin", $signed(bus.sin_out), -25);
    check("q2_cos", $signed(bus.cos_out), -2047);
    step(1'b1, 1'b0, 8'h00);
    check("q3_sin", $signed(bus.sin_out), -2047);
    check("q3_cos", $signed(bus.cos_out), 25);
    check("q3_valid", bus.out_valid, 1'b1);
    step(1'b1, 1'b0, 8'h00);

    // Full sweep of every phase, then symmetry checks on the captured samples.
    for (int p = 0; p < 256; p++) step(1'b1, 1'b1, 8'(p));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int p = 0; p < 256; p++) begin
      check("sym_half", obs_sin[p], -obs_sin[(p + 128) % 256]);
      check("sin_cos", obs_sin[p], obs_cos[(p + 192) % 256]);
      check("range", ((obs_sin[p] <= AMP) && (obs_sin[p] >= -AMP) &&
                      (obs_cos[p] <= AMP) && (obs_cos[p] >= -AMP)), 1);
    end

    // EN stall with samples in flight; phase_valid is ignored while stalled.
    step(1'b1, 1'b1, 8'h10);
    step(1'b1, 1'b1, 8'h20);
    step(1'b1, 1'b1, 8'h30);
    check("stall_pre", $signed(bus.sin_out), ref_sin(8'h10));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom_range(255)));
    check("stall_hold", $signed(bus.sin_out), ref_sin(8'h10));
    step(1'b1, 1'b0, 8'h00);
    check("stall_b", $signed(bus.sin_out), ref_sin(8'h20));
    step(1'b1, 1'b0, 8'h00);
    check("stall_c", $signed(bus.sin_out), ref_sin(8'h30));
    step(1'b1, 1'b0, 8'h00);
    check("stall_drain", bus.out_valid, 1'b0);

    // Bubbles: valid pattern 1,0,0,1.
    step(1'b1, 1'b1, 8'h33);
    step(1'b1, 1'b0, 8'h44);
    step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b1, 8'h66);
    step(1'b1, 1'b0, 8'h00);
    check("bub_hold", $signed(bus.cos_out), ref_cos(8'h33));
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("bub_second", $signed(bus.sin_out), ref_sin(8'h66));

    // Upstream accumulator with inc=1: periodic output and the 0xFF -> 0x00 step.
    acc       = 8'h00;
    have_prev = 1'b0;
    prev_sin  = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, acc);
      acc = acc + 8'd1;
      if (m_v[3]) begin
        check("periodic", $signed(bus.sin_out), obs_sin[m_p[3]]);
        if (m_p[3] == 8'h00 && have_prev) begin
          check("wrap_ff", prev_sin, -25);
          check("wrap_00", $signed(bus.sin_out), 25);
        end
        prev_sin  = $signed(bus.sin_out);
        have_prev = 1'b1;
      end
    end

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_sin", $signed(bus.sin_out), 0);
    check("arst_cos", $signed(bus.cos_out), 0);
    check("arst_valid", bus.out_valid, 1'b0);
    model_clear();
    step(1'b1, 1'b1, 8'h55);
    #2;
    rst = 1'b0;
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("post_rst_idle", bus.out_valid, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    check("post_rst_valid", bus.out_valid, 1'b1);
    check("post_rst_sin", $signed(bus.sin_out), 25);
    check("post_rst_cos", $signed(bus.cos_out), 2047);
    step(1'b1, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
